hazard_controller: RTL and testbench

- Pipeline sequencing controller for the 5-stage RISC-V core; sits beside the forwarding unit.
- Handles the hazards forwarding cannot resolve: load-use stalls, taken-branch/jump flushes, and the multi-cycle mul/div unit start/done handshake.
- Drives stall/flush/bubble controls for the PC, IF/ID, ID/EX and EX/MEM buffers.
- Keeps stall/flush performance counters.

---
 rtl/riscv_pkg.sv | 16 +
 rtl/hazard_detect.sv | 28 ++
 rtl/hazard_controller.sv | 142 ++++++++++++++
 tb/tb_hazard_controller.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the 5-stage RISC-V core pipeline control blocks.
// Used by the forwarding unit, the hazard controller and its load-use comparator.
package riscv_pkg;

  localparam int RF_REG_BITS = 5;
  localparam int REG_ZERO    = 0;

  // Wide enough for the largest legal mul/div timeout (65535).
  localparam int TO_BITS = 16;

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } hz_state_t;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use comparator: flags an IF/ID source that needs the
// result of a load still sitting in ID/EX.
module hazard_detect
  import riscv_pkg::*;
#(
  parameter int REG_BITS = RF_REG_BITS
) (
  input  logic [REG_BITS-1:0] i_rs1,
  input  logic [REG_BITS-1:0] i_rs2,
  input  logic                i_rs1Used,
  input  logic                i_rs2Used,
  input  logic [REG_BITS-1:0] i_rd,
  input  logic                i_memRead,
  input  logic                i_regWrEn,
  output logic                o_loadUse
);

  logic w_producer;
  logic w_rs1Hit;
  logic w_rs2Hit;

  // x0 is hard-wired, so a load targeting it never creates a dependency.
  assign w_producer = i_memRead && i_regWrEn && (i_rd != REG_BITS'(REG_ZERO));
  assign w_rs1Hit   = i_rs1Used && (i_rs1 == i_rd);
  assign w_rs2Hit   = i_rs2Used && (i_rs2 == i_rd);
  assign o_loadUse  = w_producer && (w_rs1Hit || w_rs2Hit);

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: load-use stalls, taken-branch flushes and
// the multi-cycle mul/div start/done handshake, plus stall/flush counters.
module hazard_controller
  import riscv_pkg::*;
#(
  parameter int REG_BITS   = RF_REG_BITS,
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_BITS   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REG_BITS-1:0] rs1_id,
  input  logic [REG_BITS-1:0] rs2_id,
  input  logic                rs1_used_id,
  input  logic                rs2_used_id,
  input  logic [REG_BITS-1:0] rd_ex,
  input  logic                memRead_ex,
  input  logic                regWrEn_ex,
  input  logic                md_op_ex,
  input  logic                branch_taken_ex,
  input  logic                md_done,
  output logic                stall_pc,
  output logic                stall_ifid,
  output logic                stall_idex,
  output logic                flush_ifid,
  output logic                flush_idex,
  output logic                bubble_exmem,
  output logic                md_start,
  output logic                md_error,
  output logic [CNT_BITS-1:0] stall_count,
  output logic [CNT_BITS-1:0] flush_count
);

  hz_state_t           r_state;
  hz_state_t           w_nextState;
  logic [TO_BITS-1:0]  r_toCnt;
  logic                r_mdError;
  logic [CNT_BITS-1:0] r_stallCount;
  logic [CNT_BITS-1:0] r_flushCount;
  logic                w_loadUse;
  logic                w_timeout;

  hazard_detect #(.REG_BITS(REG_BITS)) u_detect (
    .i_rs1     (rs1_id),
    .i_rs2     (rs2_id),
    .i_rs1Used (rs1_used_id),
    .i_rs2Used (rs2_used_id),
    .i_rd      (rd_ex),
    .i_memRead (memRead_ex),
    .i_regWrEn (regWrEn_ex),
    .o_loadUse (w_loadUse)
  );

  // md_done wins over a timeout landing on the same cycle.
  assign w_timeout = (r_state == MD_WAIT) && !md_done &&
                     (r_toCnt == TO_BITS'(MD_TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      RUN:     if (!branch_taken_ex && md_op_ex) w_nextState = MD_WAIT;
      MD_WAIT: if (md_done || w_timeout)         w_nextState = RUN;
      default: w_nextState = RUN;
    endcase
  end

  always_comb begin
    stall_pc     = 1'b0;
    stall_ifid   = 1'b0;
    stall_idex   = 1'b0;
    flush_ifid   = 1'b0;
    flush_idex   = 1'b0;
    bubble_exmem = 1'b0;
    md_start     = 1'b0;
    if (!rst) begin
      case (r_state)
        RUN: begin
          if (branch_taken_ex) begin
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
          end else if (md_op_ex) begin
            md_start     = 1'b1;
            stall_pc     = 1'b1;
            stall_ifid   = 1'b1;
            stall_idex   = 1'b1;
            bubble_exmem = 1'b1;
          end else if (w_loadUse) begin
            stall_pc   = 1'b1;
            stall_ifid = 1'b1;
            flush_idex = 1'b1;
          end
        end
        MD_WAIT: begin
          stall_pc     = 1'b1;
          stall_ifid   = 1'b1;
          stall_idex   = 1'b1;
          bubble_exmem = !md_done;
          flush_idex   = w_timeout;
        end
        default: ;
      endcase
    end
  end

  // Timeout counter restarts on every entry into MD_WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_toCnt      <= '0;
      r_mdError    <= 1'b0;
      r_stallCount <= '0;
      r_flushCount <= '0;
    end else begin
      if (r_state == RUN) begin
        r_toCnt <= '0;
      end else begin
        r_toCnt <= r_toCnt + TO_BITS'(1);
      end
      if (w_timeout) begin
        r_mdError <= 1'b1;
      end
      if (stall_pc) begin
        r_stallCount <= r_stallCount + CNT_BITS'(1);
      end
      if ((r_state == RUN) && branch_taken_ex) begin
        r_flushCount <= r_flushCount + CNT_BITS'(1);
      end
    end
  end

  assign md_error    = r_mdError;
  assign stall_count = r_stallCount;
  assign flush_count = r_flushCount;

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: two instances (timeouts 64 and 4)
// share stimulus and are compared every cycle against a behavioural model.
module tb_hazard_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] rs1Id = '0;
  logic [4:0] rs2Id = '0;
  logic       rs1Used = 1'b0;
  logic       rs2Used = 1'b0;
  logic [4:0] rdEx = '0;
  logic       memReadEx = 1'b0;
  logic       regWrEnEx = 1'b0;
  logic       mdOpEx = 1'b0;
  logic       branchTakenEx = 1'b0;
  logic       mdDone = 1'b0;

  logic [1:0]  stallPc, stallIfid, stallIdex, flushIfid, flushIdex, bubbleExmem, mdStart, mdError;
  logic [31:0] stallCount [2];
  logic [31:0] flushCount [2];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  hazard_controller #(.REG_BITS(5), .MD_TIMEOUT(64), .CNT_BITS(32)) dutA (
    .clk(clk), .rst(rst), .rs1_id(rs1Id), .rs2_id(rs2Id),
    .rs1_used_id(rs1Used), .rs2_used_id(rs2Used), .rd_ex(rdEx),
    .memRead_ex(memReadEx), .regWrEn_ex(regWrEnEx), .md_op_ex(mdOpEx),
    .branch_taken_ex(branchTakenEx), .md_done(mdDone),
    .stall_pc(stallPc[0]), .stall_ifid(stallIfid[0]), .stall_idex(stallIdex[0]),
    .flush_ifid(flushIfid[0]), .flush_idex(flushIdex[0]), .bubble_exmem(bubbleExmem[0]),
    .md_start(mdStart[0]), .md_error(mdError[0]),
    .stall_count(stallCount[0]), .flush_count(flushCount[0])
  );

  hazard_controller #(.REG_BITS(5), .MD_TIMEOUT(4), .CNT_BITS(32)) dutB (
    .clk(clk), .rst(rst), .rs1_id(rs1Id), .rs2_id(rs2Id),
    .rs1_used_id(rs1Used), .rs2_used_id(rs2Used), .rd_ex(rdEx),
    .memRead_ex(memReadEx), .regWrEn_ex(regWrEnEx), .md_op_ex(mdOpEx),
    .branch_taken_ex(branchTakenEx), .md_done(mdDone),
    .stall_pc(stallPc[1]), .stall_ifid(stallIfid[1]), .stall_idex(stallIdex[1]),
    .flush_ifid(flushIfid[1]), .flush_idex(flushIdex[1]), .bubble_exmem(bubbleExmem[1]),
    .md_start(mdStart[1]), .md_error(mdError[1]),
    .stall_count(stallCount[1]), .flush_count(flushCount[1])
  );

  task automatic checkOutput(input string name, input int idx,
                             input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s dut%0d: got %0h required %0h at %0t", name, idx, act, req, $time);
    end
  endtask

  task automatic applyStimulus(input bit ml, input bit rw, input int rd,
                               input int r1, input bit u1, input int r2, input bit u2,
                               input bit md, input bit br, input bit dn);
    @(posedge clk);
    #1;
    memReadEx     = ml;
    regWrEnEx     = rw;
    rdEx          = 5'(rd);
    rs1Id         = 5'(r1);
    rs1Used       = u1;
    rs2Id         = 5'(r2);
    rs2Used       = u2;
    mdOpEx        = md;
    branchTakenEx = br;
    mdDone        = dn;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Behavioural model: per instance, whether a mul/div is outstanding and how
  // many wait cycles it has already spent.
  bit          mWait [2];
  int          mLen  [2];
  bit          mErr  [2];
  logic [31:0] mStall[2];
  logic [31:0] mFlush[2];

  function automatic int tmoOf(input int i);
    return (i == 0) ? 64 : 4;
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [6:0] eCtrl;
      logic [6:0] aCtrl;
      bit         loadUse;
      bit         timedOut;
      eCtrl = '0;
      aCtrl = {stallPc[i], stallIfid[i], stallIdex[i], flushIfid[i],
               flushIdex[i], bubbleExmem[i], mdStart[i]};
      if (rst) begin
        checkOutput("ctrlRst", i, 32'(aCtrl), 32'd0);
        checkOutput("errRst", i, 32'(mdError[i]), 32'd0);
        checkOutput("stallCntRst", i, stallCount[i], 32'd0);
        checkOutput("flushCntRst", i, flushCount[i], 32'd0);
        mWait[i] = 0; mLen[i] = 0; mErr[i] = 0; mStall[i] = 0; mFlush[i] = 0;
      end else begin
        loadUse  = memReadEx && regWrEnEx && (rdEx != 0) &&
                   ((rs1Used && rs1Id == rdEx) || (rs2Used && rs2Id == rdEx));
        timedOut = 0;
        if (!mWait[i]) begin
          if (branchTakenEx)  eCtrl = 7'b0001100;
          else if (mdOpEx)    eCtrl = 7'b1110011;
          else if (loadUse)   eCtrl = 7'b1100100;
        end else begin
          timedOut = !mdDone && (mLen[i] + 1 == tmoOf(i));
          eCtrl = {3'b111, 1'b0, timedOut, !mdDone, 1'b0};
        end
        checkOutput("ctrl", i, 32'(aCtrl), 32'(eCtrl));
        checkOutput("mdError", i, 32'(mdError[i]), 32'(mErr[i]));
        checkOutput("stallCount", i, stallCount[i], mStall[i]);
        checkOutput("flushCount", i, flushCount[i], mFlush[i]);
        if (eCtrl[6]) mStall[i] = mStall[i] + 1;
        if (!mWait[i]) begin
          if (branchTakenEx) mFlush[i] = mFlush[i] + 1;
          else if (mdOpEx) begin mWait[i] = 1; mLen[i] = 0; end
        end else if (mdDone || timedOut) begin
          mWait[i] = 0;
          if (timedOut) mErr[i] = 1;
        end else begin
          mLen[i] = mLen[i] + 1;
        end
      end
    end
  end

  initial begin
    logic [31:0] s0;

    repeat (2) @(negedge clk);
    checkOutput("resetStall", 0, stallCount[0], 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Load-use on rs1, then the same with rd=x0.
    applyStimulus(1, 1, 5, 5, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("luStallPc", 0, 32'(stallPc[0]), 32'd1);
    checkOutput("luStallIfid", 0, 32'(stallIfid[0]), 32'd1);
    checkOutput("luFlushIdex", 0, 32'(flushIdex[0]), 32'd1);
    checkOutput("luStallIdex", 0, 32'(stallIdex[0]), 32'd0);
    idle();
    @(negedge clk);
    checkOutput("luOneCycle", 0, 32'(stallPc[0]), 32'd0);
    checkOutput("luStallCnt", 0, stallCount[0], 32'd1);
    applyStimulus(1, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("luRdZero", 0, 32'(stallPc[0]), 32'd0);

    // rs2 match masked by rs2_used_id, then unmasked.
    applyStimulus(1, 1, 7, 3, 1, 7, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("rs2Masked", 0, 32'(stallPc[0]), 32'd0);
    applyStimulus(1, 1, 7, 3, 1, 7, 1, 0, 0, 0);
    @(negedge clk);
    checkOutput("rs2Used", 0, 32'(stallPc[0]), 32'd1);

    // Taken branch overrides a simultaneous load-use.
    applyStimulus(1, 1, 5, 5, 1, 0, 0, 0, 1, 0);
    @(negedge clk);
    checkOutput("brFlushIfid", 0, 32'(flushIfid[0]), 32'd1);
    checkOutput("brFlushIdex", 0, 32'(flushIdex[0]), 32'd1);
    checkOutput("brNoStall", 0, 32'(stallPc[0]), 32'd0);
    idle();
    @(negedge clk);
    checkOutput("brFlushCnt", 0, flushCount[0], 32'd1);
    checkOutput("brStallCnt", 0, stallCount[0], 32'd2);

    // Timeout on the MD_TIMEOUT=4 instance, md_done withheld.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    checkOutput("toStart", 1, 32'(mdStart[1]), 32'd1);
    for (int w = 1; w <= 4; w++) begin
      idle();
      @(negedge clk);
      if (w == 4) begin
        checkOutput("toFlushIdex", 1, 32'(flushIdex[1]), 32'd1);
        checkOutput("toBubble", 1, 32'(bubbleExmem[1]), 32'd1);
        checkOutput("toErrNotYet", 1, 32'(mdError[1]), 32'd0);
      end
    end
    idle();
    @(negedge clk);
    checkOutput("toErrSet", 1, 32'(mdError[1]), 32'd1);
    checkOutput("toBackToRun", 1, 32'(stallPc[1]), 32'd0);
    checkOutput("longStillWaits", 0, 32'(stallPc[0]), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    checkOutput("releaseBubble", 0, 32'(bubbleExmem[0]), 32'd0);
    idle();
    @(negedge clk);
    checkOutput("errSticky", 1, 32'(mdError[1]), 32'd1);

    // Mul/div with md_done ten cycles after the start.
    s0 = stallCount[0];
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    checkOutput("mdStart", 0, 32'(mdStart[0]), 32'd1);
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, (k == 10));
      @(negedge clk);
      checkOutput("mdStartOnce", 0, 32'(mdStart[0]), 32'd0);
      checkOutput("mdStallHeld", 0, 32'(stallIdex[0]), 32'd1);
      if (k == 10) checkOutput("mdDoneBubble", 0, 32'(bubbleExmem[0]), 32'd0);
    end
    idle();
    @(negedge clk);
    checkOutput("mdStallCnt", 0, stallCount[0] - s0, 32'd11);
    checkOutput("mdRun", 0, 32'(stallPc[0]), 32'd0);

    // Asynchronous reset in the middle of MD_WAIT.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    repeat (3) idle();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkOutput("asyncStall", 0, 32'(stallPc[0]), 32'd0);
    checkOutput("asyncBubble", 0, 32'(bubbleExmem[0]), 32'd0);
    checkOutput("asyncCnt", 0, stallCount[0], 32'd0);
    checkOutput("asyncErr", 1, 32'(mdError[1]), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle();
    @(negedge clk);
    checkOutput("noReissue", 0, 32'(mdStart[0]), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    checkOutput("strayDone", 0, 32'(stallPc[0]), 32'd0);

    // Randomized traffic; the compare process does the checking.
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      #1;
      rst           = ($urandom_range(0, 399) == 0);
      memReadEx     = ($urandom_range(0, 1) == 1);
      regWrEnEx     = ($urandom_range(0, 3) != 0);
      rdEx          = 5'($urandom_range(0, 3));
      rs1Id         = 5'($urandom_range(0, 3));
      rs2Id         = 5'($urandom_range(0, 3));
      rs1Used       = ($urandom_range(0, 1) == 1);
      rs2Used       = ($urandom_range(0, 1) == 1);
      mdOpEx        = ($urandom_range(0, 9) == 0);
      branchTakenEx = ($urandom_range(0, 5) == 0);
      mdDone        = (n < 1500) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 79) == 0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) idle();
    @(negedge clk);
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
